// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port-owner constants and alignment mask for mem_port_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic       OWNER_CPU = 1'b0;
   localparam logic       OWNER_DMA = 1'b1;
   localparam logic [1:0] MISALIGN  = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb & MISALIGN) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner pick between the CPU and DMA requests.
module mem_arb_sel
   import mem_arb_pkg::*;
(
   input  logic cpu_req_i,
   input  logic dma_req_i,
   input  logic last_owner_i,
   output logic any_req_o,
   output logic winner_o
);

   always_comb begin
      any_req_o = cpu_req_i | dma_req_i;
      winner_o  = OWNER_CPU;
      if (cpu_req_i && dma_req_i) begin
         // contention goes to whichever port was not granted last
         winner_o = (last_owner_i == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
      end else if (dma_req_i) begin
         winner_o = OWNER_DMA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between CPU and DMA ports with fixed-latency accesses.
// Optional ARB_FIXED_PRIO_EN: CPU always wins simultaneous requests (no round-robin pointer).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic              dma_err,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              any_req;
   logic              winner;
   logic              last_owner;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              in_access;
   logic              in_resp;

   mem_arb_sel u_sel (
      .cpu_req_i    (cpu_req),
      .dma_req_i    (dma_req),
      .last_owner_i (last_owner),
      .any_req_o    (any_req),
      .winner_o     (winner)
   );

`ifdef ARB_FIXED_PRIO_EN
   // a constant "DMA went last" makes every tie resolve to the CPU
   assign last_owner = OWNER_DMA;
`else
   logic rr_q, rr_d;

   assign rr_d       = (state_q == IDLE && any_req) ? winner : rr_q;
   assign last_owner = rr_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rr_q <= OWNER_DMA;
      else     rr_q <= rr_d;
   end
`endif

   assign sel_we    = (winner == OWNER_DMA) ? dma_we    : cpu_we;
   assign sel_addr  = (winner == OWNER_DMA) ? dma_addr  : cpu_addr;
   assign sel_wdata = (winner == OWNER_DMA) ? dma_wdata : cpu_wdata;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d = winner;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               rdata_d = '0;
               cnt_d   = CNT_INIT;
               err_d   = is_misaligned(sel_addr[1:0]);
               state_d = is_misaligned(sel_addr[1:0]) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         owner_q <= OWNER_CPU;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_access = (state_q == ACCESS);
   assign in_resp   = (state_q == RESP);

   assign mem_en    = in_access;
   assign mem_we    = in_access & we_q;
   assign mem_addr  = in_access ? addr_q  : '0;
   assign mem_wdata = in_access ? wdata_q : '0;

   assign cpu_ack   = in_resp & (owner_q == OWNER_CPU);
   assign cpu_err   = cpu_ack & err_q;
   assign cpu_rdata = cpu_ack ? rdata_q : '0;
   assign dma_ack   = in_resp & (owner_q == OWNER_DMA);
   assign dma_err   = dma_ack & err_q;
   assign dma_rdata = dma_ack ? rdata_q : '0;

   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard testbench for mem_port_arbiter with a behavioural word memory.
module tb_mem_port_arbiter;

   localparam int   MEM_LAT = 2;
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_ack, cpu_err;
   logic [31:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_ack, dma_err;
   logic [31:0] dma_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy, owner;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        own;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] shadow [int];

   logic        pl_en = 1'b0;
   logic [31:0] pl_addr = '0, pl_data = '0;
   logic [31:0] mem [0:255];

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (pl_en) mem[pl_addr[9:2]] <= pl_data;
      else if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr[9:2]];

   mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_err   (cpu_err),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_ack   (dma_ack),
      .dma_err   (dma_err),
      .dma_rdata (dma_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      pl_addr = addr;
      pl_data = data;
      pl_en   = 1'b1;
      @(posedge CLK); #1;
      pl_en = 1'b0;
      shadow[int'(addr >> 2)] = data;
   endtask

   task automatic apply_reset();
      cpu_req = 1'b0;
      dma_req = 1'b0;
      RST     = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   // One isolated transaction: scoreboard push, bounded wait for ack, pop and compare.
   task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chg);
      exp_t        e;
      logic        mis, ack_port, got;
      logic [31:0] rd;
      logic        er;
      int          cyc, en_cyc, extra, exp_cyc, exp_en;
      mis     = (addr[1:0] != 2'b00);
      exp_cyc = mis ? 1 : MEM_LAT + 1;
      exp_en  = mis ? 0 : MEM_LAT;
      e.own   = port;
      e.err   = mis;
      e.rdata = (we || mis) ? 32'h0 : shadow[int'(addr >> 2)];
      if (we && !mis) shadow[int'(addr >> 2)] = wdata;
      sb_q.push_back(e);
      if (port == OWN_CPU) begin
         cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end else begin
         dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
      end
      cyc = 0; en_cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge CLK);
         if (mem_en) begin
            en_cyc++;
            checks++;
            if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) begin
               failures++;
               $display("FAIL mem_bus: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                        mem_addr, mem_we, mem_wdata, addr, we, wdata);
            end
         end
         if (cpu_ack || dma_ack) begin
            got = 1'b1;
         end else begin
            @(posedge CLK); #1;
            cyc++;
            if (chg && cyc == 1) begin
               if (port == OWN_CPU) begin cpu_addr = addr ^ 32'h30; cpu_wdata = ~wdata; end
               else begin dma_addr = addr ^ 32'h30; dma_wdata = ~wdata; end
            end
         end
      end
      e = sb_q.pop_front();
      if (!got) begin
         checks++; failures++;
         $display("FAIL ack_timeout: no ack after %0d cycles, required ack at cycle %0d", cyc, exp_cyc);
      end else begin
         ack_port = dma_ack;
         rd = ack_port ? dma_rdata : cpu_rdata;
         er = ack_port ? dma_err : cpu_err;
         checks++;
         if ((cpu_ack && dma_ack) || ack_port !== e.own) begin
            failures++;
            $display("FAIL ack_port: cpu_ack=%b dma_ack=%b required port %b", cpu_ack, dma_ack, e.own);
         end
         checks++;
         if (rd !== e.rdata) begin
            failures++;
            $display("FAIL rdata: got %h required %h", rd, e.rdata);
         end
         checks++;
         if (er !== e.err) begin
            failures++;
            $display("FAIL err: got %b required %b", er, e.err);
         end
         checks++;
         if (owner !== e.own) begin
            failures++;
            $display("FAIL owner: got %b required %b", owner, e.own);
         end
         checks++;
         if (cyc != exp_cyc) begin
            failures++;
            $display("FAIL ack_latency: got cycle %0d required %0d", cyc, exp_cyc);
         end
         checks++;
         if (en_cyc != exp_en) begin
            failures++;
            $display("FAIL mem_en_cycles: got %0d required %0d", en_cyc, exp_en);
         end
      end
      @(posedge CLK); #1;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      extra = 0;
      repeat (3) begin
         @(negedge CLK);
         if (cpu_ack || dma_ack || busy) extra++;
         @(posedge CLK); #1;
      end
      checks++;
      if (extra != 0) begin
         failures++;
         $display("FAIL single_ack: %0d extra busy/ack cycles, required 0", extra);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if ({busy, mem_en, mem_we, cpu_ack, dma_ack, owner} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: busy/en/we/cack/dack/owner=%b required 000000",
                  {busy, mem_en, mem_we, cpu_ack, dma_ack, owner});
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h required all 0",
                  mem_addr, mem_wdata, cpu_rdata, dma_rdata);
      end
      RST = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_no_req: busy=%b required 0", busy);
      end
   endtask

   task automatic test_cpu_read();
      preload(32'h10, 32'hDEADBEEF);
      preload(32'h30, 32'hA5A5A5A5);
      run_txn(OWN_CPU, 1'b0, 32'h10, 32'h0, 1'b0);
   endtask

   task automatic test_dma_write_cpu_read();
      run_txn(OWN_DMA, 1'b1, 32'h20, 32'h12345678, 1'b0);
      checks++;
      if (mem[8] !== 32'h12345678) begin
         failures++;
         $display("FAIL dma_write_commit: mem=%h required 12345678", mem[8]);
      end
      run_txn(OWN_CPU, 1'b0, 32'h20, 32'h0, 1'b0);
   endtask

   task automatic test_misaligned();
      run_txn(OWN_CPU, 1'b0, 32'h13, 32'h0, 1'b0);
      run_txn(OWN_DMA, 1'b1, 32'h22, 32'hFFFF0000, 1'b0);
      checks++;
      if (mem[8] !== 32'h12345678) begin
         failures++;
         $display("FAIL misaligned_write: mem=%h required 12345678", mem[8]);
      end
   endtask

   task automatic test_addr_change();
      run_txn(OWN_CPU, 1'b0, 32'h10, 32'h0, 1'b1);
      run_txn(OWN_DMA, 1'b1, 32'h24, 32'h0BADF00D, 1'b1);
   endtask

   task automatic test_reset_mid_access();
      int extra;
      cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55AA55AA; cpu_req = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (mem_we !== 1'b1) begin
         failures++;
         $display("FAIL mid_access_we: got %b required 1", mem_we);
      end
      #2 RST = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_abort: we=%b en=%b busy=%b required 000", mem_we, mem_en, busy);
      end
      cpu_req = 1'b0;
      #1 RST = 1'b0;
      extra = 0;
      repeat (4) begin
         @(negedge CLK);
         if (cpu_ack || dma_ack || busy) extra++;
      end
      @(posedge CLK); #1;
      checks++;
      if (extra != 0) begin
         failures++;
         $display("FAIL abort_no_ack: %0d ack/busy cycles, required 0", extra);
      end
      checks++;
      if (mem[12] !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL abort_mem: mem=%h required a5a5a5a5", mem[12]);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   n, cyc, last_cyc;
      logic ack_port;
      logic [31:0] rd;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
         e.own = OWN_CPU;
`else
         e.own = (i % 2 == 0) ? OWN_CPU : OWN_DMA;
`endif
         e.rdata = (e.own == OWN_CPU) ? shadow[4] : shadow[8];
         e.err   = 1'b0;
         sb_q.push_back(e);
      end
      cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
      dma_we = 1'b0; dma_addr = 32'h20; dma_req = 1'b1;
      n = 0; cyc = 0; last_cyc = -1;
      while (n < 4 && cyc < 80) begin
         @(negedge CLK);
         if (cpu_ack || dma_ack) begin
            e = sb_q.pop_front();
            ack_port = dma_ack;
            rd = ack_port ? dma_rdata : cpu_rdata;
            checks++;
            if ((cpu_ack && dma_ack) || ack_port !== e.own || owner !== e.own) begin
               failures++;
               $display("FAIL rr_order[%0d]: port=%b owner=%b required %b", n, ack_port, owner, e.own);
            end
            checks++;
            if (rd !== e.rdata) begin
               failures++;
               $display("FAIL rr_rdata[%0d]: got %h required %h", n, rd, e.rdata);
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != MEM_LAT + 2) begin
                  failures++;
                  $display("FAIL rr_spacing[%0d]: got %0d cycles required %0d", n, cyc - last_cyc, MEM_LAT + 2);
               end
            end
            last_cyc = cyc;
            n++;
         end
         @(posedge CLK); #1;
         cyc++;
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      if (n < 4) begin
         checks++; failures++;
         $display("FAIL rr_timeout: got %0d acks required 4", n);
         sb_q.delete();
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_dma_write_cpu_read();
      test_misaligned();
      test_addr_change();
      test_reset_mid_access();
      test_round_robin();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
